// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file control front-end.
//   state_e    : sweep/run FSM encoding (2 bits)
//   fwd_sel_e  : read-data source chosen by the forwarding mux
//   fwd_select : priority resolution for the read-data source
package regfile_ctrl_pkg;

  typedef enum logic [1:0] {
    StRst   = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SelRam  = 2'd0,
    SelFwd  = 2'd1,
    SelZero = 2'd2
  } fwd_sel_e;

  // Hard-wired zero wins over forwarding, forwarding wins over the RAM.
  function automatic fwd_sel_e fwd_select(input logic zero_hit, input logic fwd_hit);
    fwd_sel_e sel;
    if (zero_hit) begin
      sel = SelZero;
    end else if (fwd_hit) begin
      sel = SelFwd;
    end else begin
      sel = SelRam;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Bundle between the pipeline, the register-file control block and the 2R1W RAM.
//   master : pipeline/RAM side (drives read/write requests and RAM read data)
//   slave  : regfile_ctrl side (drives read results, status and all RAM controls)
interface regfile_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  // Pipeline side
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  ready;
  logic                  wr_drop;
  // RAM side
  logic [ADDR_WIDTH-1:0] ram_addr_r_a;
  logic [ADDR_WIDTH-1:0] ram_addr_r_b;
  logic [ADDR_WIDTH-1:0] ram_addr_w;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_data_out_a;
  logic [DATA_WIDTH-1:0] ram_data_out_b;

  modport master (
    output rd_addr_a, rd_addr_b, wr_addr, wr_data, wr_en, ram_data_out_a, ram_data_out_b,
    input  rd_data_a, rd_data_b, ready, wr_drop,
    input  ram_addr_r_a, ram_addr_r_b, ram_addr_w, ram_data_in, ram_we
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_addr, wr_data, wr_en, ram_data_out_a, ram_data_out_b,
    output rd_data_a, rd_data_b, ready, wr_drop,
    output ram_addr_r_a, ram_addr_r_b, ram_addr_w, ram_data_in, ram_we
  );

endinterface

// File: rtl/regfile_fwd.sv
// Per-read-port write-forwarding stage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   rd_addr_i     : read index presented this cycle
//   wr_addr_i, wr_data_i, wr_en_i : write presented this cycle (wr_en_i already qualified)
//   ram_data_i    : registered RAM read data for the previous cycle's address
//   rd_data_o     : read result, forwarded or hard-wired zero where applicable
module regfile_fwd
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          ZERO_REG   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;

  // Everything is re-captured every cycle; the RAM returns old data on
  // read-during-write, so the write seen this cycle is replayed next cycle.
  always_comb begin
    rd_addr_d = rd_addr_i;
    wr_addr_d = wr_addr_i;
    wr_data_d = wr_data_i;
    wr_en_d   = wr_en_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  always_comb begin
    rd_data_o = ram_data_i;
    unique case (fwd_select(ZERO_REG && (rd_addr_q == '0), wr_en_q && (wr_addr_q == rd_addr_q)))
      SelZero: rd_data_o = '0;
      SelFwd:  rd_data_o = wr_data_q;
      default: rd_data_o = ram_data_i;
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file control front-end: clears every RAM entry after reset, then
// passes pipeline reads/writes to the 2R1W RAM with same-cycle write forwarding.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : pipeline requests/results, ready/wr_drop status and all RAM ports
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter bit                    ZERO_REG    = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  regfile_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_drop_q, wr_drop_d;
  logic                  zero_wr;
  logic                  run_we;

  assign zero_wr = ZERO_REG && (bus.wr_addr == '0);
  assign run_we  = (state_q == StRun) && bus.wr_en && !zero_wr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRst;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRst:   state_d = StClear;
      StClear: begin
        cnt_d = cnt_q + 1'b1;  // wraps to 0 on the last entry
        if (cnt_q == LastAddr) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StRst;
    endcase
    // Registered copy of "in RUN", so ready tracks state_q exactly.
    ready_d   = (state_d == StRun);
    wr_drop_d = wr_drop_q || (bus.wr_en && (state_q != StRun));
  end

  // Outputs
  always_comb begin
    bus.ram_we      = 1'b0;
    bus.ram_addr_w  = cnt_q;
    bus.ram_data_in = CLEAR_VALUE;
    unique case (state_q)
      StClear: bus.ram_we = 1'b1;
      StRun: begin
        bus.ram_we      = run_we;
        bus.ram_addr_w  = bus.wr_addr;
        bus.ram_data_in = bus.wr_data;
      end
      default: bus.ram_we = 1'b0;
    endcase
  end

  assign bus.ram_addr_r_a = bus.rd_addr_a;
  assign bus.ram_addr_r_b = bus.rd_addr_b;
  assign bus.ready        = ready_q;
  assign bus.wr_drop      = wr_drop_q;

  regfile_fwd #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_fwd_a (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .rd_addr_i  (bus.rd_addr_a),
    .wr_addr_i  (bus.wr_addr),
    .wr_data_i  (bus.wr_data),
    .wr_en_i    (run_we),
    .ram_data_i (bus.ram_data_out_a),
    .rd_data_o  (bus.rd_data_a)
  );

  regfile_fwd #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_fwd_b (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .rd_addr_i  (bus.rd_addr_b),
    .wr_addr_i  (bus.wr_addr),
    .wr_data_i  (bus.wr_data),
    .wr_en_i    (run_we),
    .ram_data_i (bus.ram_data_out_b),
    .rd_data_o  (bus.rd_data_b)
  );

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Control front-end for the CPU register file built on the 2-read/1-write port RAM. After reset it runs a clear sweep that writes CLEAR_VALUE to every entry. It then passes pipeline reads and writes to the RAM. It forwards same-cycle write data so that a read issued in the same cycle as a write to the same register returns the new value. It sits between the decode/write-back stages and the register-file RAM, and drives all RAM ports.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 4, register index width; depth = 2^ADDR_WIDTH
- CLEAR_VALUE, 0, value written to every entry during the clear sweep
- ZERO_REG, 0, when 1: register 0 reads as 0 and writes to it are discarded
- clk  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH  read indices; data is returned one cycle later
- wr_addr  in  ADDR_WIDTH  write index
- wr_data  in  DATA_WIDTH  write data
- wr_en  in  1  write strobe
- rd_data_a, rd_data_b  out  DATA_WIDTH  read results, including forwarding
- ready  out  1  high once the clear sweep is complete
- wr_drop  out  1  sticky flag: a write was attempted while ready was low
- ram_addr_r_a, ram_addr_r_b, ram_addr_w  out  ADDR_WIDTH  to the RAM
- ram_data_in  out  DATA_WIDTH; ram_we  out  1  to the RAM
- ram_data_out_a, ram_data_out_b  in  DATA_WIDTH  from the RAM (registered read, 1-cycle latency, returns old data on read-during-write)

## Operation
- **FSM states:** RST → CLEAR → RUN.
  - RST is the reset state and lasts exactly one cycle; ram_we=0.
  - CLEAR: ram_we=1, ram_addr_w=cnt, ram_data_in=CLEAR_VALUE. cnt increments each cycle. When cnt = 2^ADDR_WIDTH-1 the FSM moves to RUN, and cnt wraps to 0.
  - RUN: ram_we = wr_en & ~(ZERO_REG & wr_addr==0), ram_addr_w=wr_addr, ram_data_in=wr_data.
- **Read path:** ram_addr_r_a/b = rd_addr_a/b in every state (combinational pass-through).
- **Forwarding registers:** capture wr_addr, wr_data and the effective RUN write enable each cycle. Also capture rd_addr_a/b each cycle.
- **rd_data_x selection** (priority order):
  1. ZERO_REG=1 and the registered address is 0 → 0.
  2. Registered write enable set and registered write address equals registered read address → registered wr_data.
  3. Otherwise → ram_data_out_x.
- **wr_drop:** set when wr_en=1 while state≠RUN. It stays set until reset; the dropped write is not performed.
- **ready:** registered; 1 exactly when state=RUN.
- **Reset values:** state=RST, cnt=0, ready=0, wr_drop=0, forwarding enable=0, forwarding addresses and data=0. With forwarding enable=0, rd_data_x follows ram_data_out_x (or is 0 under the ZERO_REG rule).
- **Reset mid-operation**, including mid-sweep: immediately returns to RST; the sweep restarts from entry 0.
- **Simultaneous events:** writes in CLEAR are not queued. Reads during CLEAR are serviced but the returned data is undefined; the pipeline must wait for ready.

## Timing
- **Clear duration:** 1 + 2^ADDR_WIDTH cycles from reset release to ready=1. With the defaults that is 17 cycles.
- **Read latency:** 1 cycle, from address presented at edge T to valid data after edge T.
- **Write visibility:**
  - A write at edge T is visible to a read issued at edge T through the forwarding path.
  - It is visible to reads at edge T+1 and later through the RAM.
- **Zero added latency** versus the bare RAM; the forwarding mux is combinational after the registers.

## Structure
- Shared package holds the FSM state encoding (RST, CLEAR, RUN; 2 bits) and the forwarding-selection helper function.
- One natural sub-module, regfile_fwd. It holds the forwarding registers plus the compare/mux logic and is instantiated twice, once per read port. The FSM and counter stay in regfile_ctrl.
- The RAM is instanced beside this block at the register-file top level, not inside it.

## Test plan
- **Reset sweep:** release reset_n and check:
  - ram_we high with ram_addr_w stepping 0..15 over cycles 2..17;
  - ready rises on cycle 17;
  - then every register reads 0x00000000.
- **Forwarding:** in RUN, write 0xDEADBEEF to r5 while reading r5 on port A and r3 on port B in the same cycle. Next cycle: rd_data_a=0xDEADBEEF and rd_data_b=old r3. The cycle after that, a RAM read of r5 also returns 0xDEADBEEF.
- **Dropped write:** assert wr_en during CLEAR (cycle 5, r2←0x1234). Check:
  - wr_drop=1 and stays set;
  - after ready, r2 reads CLEAR_VALUE.
- **Zero register:** with ZERO_REG=1, write 0xFFFFFFFF to r0 and read r0 the same cycle and the next cycle. Both reads return 0 and ram_we stays 0.
- **Reset mid-sweep:** pulse reset_n low at cycle 9. Check:
  - ready=0 and wr_drop=0 immediately;
  - the sweep restarts at address 0;
  - ready rises 17 cycles after the second release.
- **Back-to-back writes:** write r7←1, then r7←2 on consecutive cycles, each with a same-cycle read of r7. The returned values are 1 then 2.
